mipi_csi_lane_rx: RTL and testbench
===================================

# mipi_csi_lane_rx

Parametrised MIPI CSI-2 high-speed receiver for 1, 2 or 4 data lanes, clocked at the bit rate. It byte-aligns each lane on the HS sync byte and merges the lanes into packet byte order. It parses and ECC-checks the 32-bit packet header, then streams long-packet payload as lane-wide words with byte enables. It sits between the D-PHY input pins and the pixel unpacker / frame-buffer address generator, and flags frame start and frame end.

## Interface
- LANES, 2, number of data lanes; legal values 1, 2, 4
- MAX_WC, 16'hFFFF, largest accepted long-packet word count; larger counts are header errors
- byte_clk8  in  1  bit clock, one sample per lane per rising edge
- reset  in  1  synchronous, active-high
- lane_in  in  LANES  HS serial data, one bit per lane, LSB first
- hs_active  in  1  high for the duration of an HS burst, low during LP/EoT
- data_out  out  8*LANES  payload word; packet byte n sits in lane slot (n mod LANES)
- data_be  out  LANES  byte enables for data_out
- data_valid  out  1  one-cycle strobe, data_out/data_be valid
- hdr_valid  out  1  one-cycle strobe, header fields valid
- data_id  out  8  {VC[1:0], DT[5:0]} of current packet
- word_count  out  16  header word count (short packets: data field)
- fs_pulse / fe_pulse  out  1  one-cycle strobe on valid DT 0x00 / 0x01
- hdr_err  out  1  one-cycle strobe, uncorrectable header or WC>MAX_WC
- pkt_err  out  1  one-cycle strobe, sync error or hs_active lost mid-packet
- crc_rx  out  16  received packet footer, valid with last data_valid+2 bytes

## Operation
- Per lane: 8-bit shift register, new bit enters at bit 7, shifts right (LSB first).
- FSM states: HUNT, HEADER, PAYLOAD, FOOTER, WAIT_EOT.
- HUNT: entered on reset and whenever hs_active is low. Each lane compares its shift register to 8'hB8.
  - All lanes match on the same cycle: bit counter cleared, go HEADER.
  - Only some lanes match: pkt_err pulses, go WAIT_EOT.
- Bit counter 0..7 wraps. Counter value 7 marks a word boundary, where each lane delivers one byte.
- HEADER: collects 4 bytes in lane order (LANES=1: 4 words; 2: 2 words; 4: 1 word). Byte0 = data_id, byte1/byte2 = WC LSB/MSB, byte3 = ECC.
- ECC: 6-bit Hamming over the 24 header bits (team-standard CSI-2 parity set); ECC[7:6] must be 0.
  - Pass: hdr_valid pulses. fs_pulse/fe_pulse pulse on DT 0x00/0x01.
  - DT ≥ 0x10 and WC ≠ 0 and WC ≤ MAX_WC: go PAYLOAD. Otherwise go WAIT_EOT.
  - Fail: hdr_err pulses, go WAIT_EOT.
- PAYLOAD: 16-bit byte counter counts remaining bytes. Each word boundary emits data_valid, with data_be = all ones, or a low-justified mask on the final partial word. Then go FOOTER.
- Footer bytes (2 CRC bytes) may share the final payload word. FOOTER captures them into crc_rx LSB-first, then goes WAIT_EOT. The CRC value is not checked.
- WAIT_EOT: ignores data until hs_active is low, then goes HUNT.
- hs_active low in HEADER/PAYLOAD/FOOTER: pkt_err pulses, go HUNT. No partial word is emitted.

## Timing
- Reset values: every output 0; FSM in HUNT; shift registers and counters 0.
- All outputs registered; strobes high exactly one byte_clk8 cycle.
- hdr_valid: the cycle after the boundary that completes byte3.
- data_valid: the cycle after each payload word boundary. This gives ≥8 cycles between strobes and at most one strobe per 8 cycles.
- Header fields hold their value until the next hdr_valid. data_out holds its value until the next data_valid.
- Reset asserted mid-packet: the next cycle is in the reset state, with no strobe emitted.
- Simultaneous sync match and hs_active falling: hs_active wins, stay HUNT.

## Configuration
- MIPI_RX_ECC_CORRECT_EN defined: a non-zero syndrome matching one header bit's parity column flips that bit. The packet is then accepted as valid; hdr_err stays low.
  - A syndrome matching a single ECC bit is also accepted.
  - Any other non-zero syndrome is an hdr_err.
- Macro undefined: any syndrome ≠ 0 is an hdr_err; detect-only.

## Test plan
- LANES=2, sync B8/B8, short header 00 00 00 ECC=0x07 → hdr_valid, fs_pulse, data_id=0x00, no data_valid.
- LANES=2, long DT 0x2B, WC=5, payload 11..15, CRC AA BB:
  - three data_valid strobes: {12,11} be=11, {14,13} be=11, {xx,15} be=01;
  - crc_rx=0xBBAA.
- LANES=4, WC=4 → exactly one data_valid, be=1111, correct byte order.
- Header with bit 9 flipped:
  - macro off → hdr_err, no payload;
  - macro on → hdr_valid with original WC.
- Sync on lane0 only (LANES=2) → pkt_err, no hdr_valid until hs_active cycles low-high.
- hs_active drops after 2 of 10 payload bytes → pkt_err, then a clean packet in the next burst is received correctly.

Source files
------------

// File: rtl/mipi_csi_lane_rx.sv
// CSI-2 HS lane receiver: per-lane sync alignment, lane merge, header ECC check, payload streaming.
// Define MIPI_RX_ECC_CORRECT_EN to correct single-bit header errors instead of only detecting them.
module mipi_csi_lane_rx #(
    parameter int          LANES  = 2,
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic                 byte_clk8,
    input  logic                 reset,
    input  logic [LANES-1:0]     lane_in,
    input  logic                 hs_active,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     data_be,
    output logic                 data_valid,
    output logic                 hdr_valid,
    output logic [7:0]           data_id,
    output logic [15:0]          word_count,
    output logic                 fs_pulse,
    output logic                 fe_pulse,
    output logic                 hdr_err,
    output logic                 pkt_err,
    output logic [15:0]          crc_rx
);

    typedef enum logic [2:0] {HUNT, HEADER, PAYLOAD, FOOTER, WAIT_EOT} state_t;

    state_t                  state_q, state_d;
    logic [LANES-1:0][7:0]   sr_q, sr_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [2:0]              hcnt_q, hcnt_d;
    logic [31:0]             hdr_q, hdr_d;
    logic [15:0]             rem_q, rem_d;
    logic [1:0]              fcnt_q, fcnt_d;
    logic [15:0]             crc_q, crc_d;
    logic [8*LANES-1:0]      data_out_q, data_out_d;
    logic [LANES-1:0]        data_be_q, data_be_d;
    logic                    data_valid_q, data_valid_d;
    logic                    hdr_valid_q, hdr_valid_d;
    logic [7:0]              data_id_q, data_id_d;
    logic [15:0]             wc_q, wc_d;
    logic                    fs_q, fs_d;
    logic                    fe_q, fe_d;
    logic                    hdr_err_q, hdr_err_d;
    logic                    pkt_err_q, pkt_err_d;

    logic [LANES-1:0]        sync_hit;
    logic [31:0]             hdr_asm;
    logic [5:0]              syndrome;
    logic [23:0]             hdr_fix;
    logic                    hdr_ok;
    logic [2:0]              nfoot;

    // Parity column of each header bit in the team CSI-2 set (bit 0 = P0).
    function automatic logic [5:0] ecc_col(input logic [4:0] i);
        case (i)
            5'd0:  return 6'h07;  5'd1:  return 6'h0B;  5'd2:  return 6'h0D;
            5'd3:  return 6'h0E;  5'd4:  return 6'h13;  5'd5:  return 6'h15;
            5'd6:  return 6'h16;  5'd7:  return 6'h19;  5'd8:  return 6'h1A;
            5'd9:  return 6'h1C;  5'd10: return 6'h23;  5'd11: return 6'h25;
            5'd12: return 6'h26;  5'd13: return 6'h29;  5'd14: return 6'h2A;
            5'd15: return 6'h2C;  5'd16: return 6'h31;  5'd17: return 6'h32;
            5'd18: return 6'h34;  5'd19: return 6'h38;  5'd20: return 6'h1F;
            5'd21: return 6'h2F;  5'd22: return 6'h37;  5'd23: return 6'h3B;
            default: return 6'h00;
        endcase
    endfunction

    // P0..P2 are seeded high, so an all-zero header carries ECC 0x07.
    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p = 6'h07;
        for (int unsigned i = 0; i < 24; i++) begin
            if (d[i]) p = p ^ ecc_col(5'(i));
        end
        return p;
    endfunction

    always_comb begin
        hdr_asm = hdr_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (32'(hcnt_q) + l < 32'd4) hdr_asm[8*(32'(hcnt_q) + l) +: 8] = sr_q[l];
        end
    end

    always_comb begin
        syndrome = ecc_calc(hdr_asm[23:0]) ^ hdr_asm[29:24];
        hdr_fix  = hdr_asm[23:0];
        hdr_ok   = (syndrome == 6'd0);
`ifdef MIPI_RX_ECC_CORRECT_EN
        for (int unsigned i = 0; i < 24; i++) begin
            if (syndrome == ecc_col(5'(i))) begin
                hdr_fix[i] = ~hdr_fix[i];
                hdr_ok     = 1'b1;
            end
        end
        if (syndrome != 6'd0 && (syndrome & (syndrome - 6'd1)) == 6'd0) hdr_ok = 1'b1;
`endif
        hdr_ok = hdr_ok && (hdr_asm[31:30] == 2'b00);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 3'd1;
        hcnt_d       = hcnt_q;
        hdr_d        = hdr_q;
        rem_d        = rem_q;
        fcnt_d       = fcnt_q;
        crc_d        = crc_q;
        data_out_d   = data_out_q;
        data_be_d    = data_be_q;
        data_id_d    = data_id_q;
        wc_d         = wc_q;
        data_valid_d = 1'b0;
        hdr_valid_d  = 1'b0;
        fs_d         = 1'b0;
        fe_d         = 1'b0;
        hdr_err_d    = 1'b0;
        pkt_err_d    = 1'b0;
        nfoot        = 3'd0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sr_d[l]     = {lane_in[l], sr_q[l][7:1]};
            sync_hit[l] = (sr_q[l] == 8'hB8);
        end

        case (state_q)
            HUNT: begin
                if (hs_active) begin
                    if (&sync_hit) begin
                        cnt_d   = 3'd0;
                        hcnt_d  = 3'd0;
                        hdr_d   = '0;
                        state_d = HEADER;
                    end else if (|sync_hit) begin
                        pkt_err_d = 1'b1;
                        state_d   = WAIT_EOT;
                    end
                end
            end
            HEADER, PAYLOAD, FOOTER: begin
                if (!hs_active) begin
                    pkt_err_d = 1'b1;
                    state_d   = HUNT;
                end else if (cnt_q == 3'd7) begin
                    if (state_q == HEADER) begin
                        hdr_d  = hdr_asm;
                        hcnt_d = hcnt_q + 3'(LANES);
                        if (32'(hcnt_q) + LANES == 32'd4) begin
                            state_d = WAIT_EOT;
                            if (!hdr_ok || (hdr_fix[5:0] >= 6'h10 && hdr_fix[23:8] > MAX_WC)) begin
                                hdr_err_d = 1'b1;
                            end else begin
                                hdr_valid_d = 1'b1;
                                data_id_d   = hdr_fix[7:0];
                                wc_d        = hdr_fix[23:8];
                                fs_d        = (hdr_fix[5:0] == 6'h00);
                                fe_d        = (hdr_fix[5:0] == 6'h01);
                                if (hdr_fix[5:0] >= 6'h10 && hdr_fix[23:8] != 16'd0) begin
                                    rem_d   = hdr_fix[23:8];
                                    state_d = PAYLOAD;
                                end
                            end
                        end
                    end else if (state_q == PAYLOAD) begin
                        data_valid_d = 1'b1;
                        data_out_d   = sr_q;
                        for (int unsigned l = 0; l < LANES; l++) begin
                            data_be_d[l] = (l < 32'(rem_q));
                        end
                        if (32'(rem_q) > 32'(LANES)) begin
                            rem_d = rem_q - 16'(LANES);
                        end else begin
                            // Footer bytes may start in the lanes left over by the last payload word.
                            for (int unsigned l = 0; l < LANES; l++) begin
                                if (l >= 32'(rem_q) && l < 32'(rem_q) + 32'd2) begin
                                    crc_d[8*(l - 32'(rem_q)) +: 8] = sr_q[l];
                                    nfoot = nfoot + 3'd1;
                                end
                            end
                            fcnt_d  = nfoot[1:0];
                            state_d = (nfoot == 3'd2) ? WAIT_EOT : FOOTER;
                        end
                    end else begin
                        for (int unsigned l = 0; l < LANES; l++) begin
                            if (32'(fcnt_q) + l < 32'd2) crc_d[8*(32'(fcnt_q) + l) +: 8] = sr_q[l];
                        end
                        if (32'(fcnt_q) + LANES >= 32'd2) state_d = WAIT_EOT;
                        else fcnt_d = fcnt_q + 2'(LANES);
                    end
                end
            end
            WAIT_EOT: begin
                if (!hs_active) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge byte_clk8) begin
        if (reset) begin
            state_q      <= HUNT;
            sr_q         <= '0;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            hdr_q        <= '0;
            rem_q        <= '0;
            fcnt_q       <= '0;
            crc_q        <= '0;
            data_out_q   <= '0;
            data_be_q    <= '0;
            data_valid_q <= 1'b0;
            hdr_valid_q  <= 1'b0;
            data_id_q    <= '0;
            wc_q         <= '0;
            fs_q         <= 1'b0;
            fe_q         <= 1'b0;
            hdr_err_q    <= 1'b0;
            pkt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            hdr_q        <= hdr_d;
            rem_q        <= rem_d;
            fcnt_q       <= fcnt_d;
            crc_q        <= crc_d;
            data_out_q   <= data_out_d;
            data_be_q    <= data_be_d;
            data_valid_q <= data_valid_d;
            hdr_valid_q  <= hdr_valid_d;
            data_id_q    <= data_id_d;
            wc_q         <= wc_d;
            fs_q         <= fs_d;
            fe_q         <= fe_d;
            hdr_err_q    <= hdr_err_d;
            pkt_err_q    <= pkt_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_be    = data_be_q;
    assign data_valid = data_valid_q;
    assign hdr_valid  = hdr_valid_q;
    assign data_id    = data_id_q;
    assign word_count = wc_q;
    assign fs_pulse   = fs_q;
    assign fe_pulse   = fe_q;
    assign hdr_err    = hdr_err_q;
    assign pkt_err    = pkt_err_q;
    assign crc_rx     = crc_q;

endmodule

// File: tb/tb_mipi_csi_lane_rx.sv
// Scoreboard bench for mipi_csi_lane_rx: a 2-lane and a 4-lane (MAX_WC=100) receiver fed bit-serial bursts.
module tb_mipi_csi_lane_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  lane2;
    logic        hs2;
    logic [3:0]  lane4;
    logic        hs4;

    logic [15:0] dout2;  logic [1:0] be2;  logic dv2, hv2, fs2, fe2, he2, pe2;
    logic [7:0]  id2;    logic [15:0] wc2, crc2;
    logic [31:0] dout4;  logic [3:0] be4;  logic dv4, hv4, fs4, fe4, he4, pe4;
    logic [7:0]  id4;    logic [15:0] wc4, crc4;

    int checks = 0;
    int errors = 0;
    logic [63:0] q2[$];
    logic [63:0] q4[$];
    logic [7:0]  pkt[$];
    logic [63:0] obs2, exp2, obs4, exp4;

    always #5 clk = ~clk;

    mipi_csi_lane_rx #(.LANES(2)) dut2 (
        .byte_clk8(clk), .reset(reset), .lane_in(lane2), .hs_active(hs2),
        .data_out(dout2), .data_be(be2), .data_valid(dv2), .hdr_valid(hv2),
        .data_id(id2), .word_count(wc2), .fs_pulse(fs2), .fe_pulse(fe2),
        .hdr_err(he2), .pkt_err(pe2), .crc_rx(crc2)
    );

    mipi_csi_lane_rx #(.LANES(4), .MAX_WC(16'd100)) dut4 (
        .byte_clk8(clk), .reset(reset), .lane_in(lane4), .hs_active(hs4),
        .data_out(dout4), .data_be(be4), .data_valid(dv4), .hdr_valid(hv4),
        .data_id(id4), .word_count(wc4), .fs_pulse(fs4), .fe_pulse(fe4),
        .hdr_err(he4), .pkt_err(pe4), .crc_rx(crc4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Equation form of the header parity, P0..P2 inverted.
    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p ^ 6'h07};
    endfunction

    function automatic logic [63:0] pack(input logic dv, input logic hv, input logic he, input logic pe,
                                         input logic [3:0] be, input logic fs, input logic fe,
                                         input logic [31:0] dout, input logic [7:0] id, input logic [15:0] wc);
        logic [31:0] d;
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        d = dv ? (dout & m) : (hv ? {8'h00, id, wc} : 32'h0);
        return {pe, he, hv, dv, (dv ? be : 4'h0), fs, fe, 22'h0, d};
    endfunction

    function automatic logic [63:0] ex_hdr(input logic fs, input logic fe, input logic [7:0] id, input logic [15:0] wc);
        return {4'b0010, 4'h0, fs, fe, 22'h0, 8'h00, id, wc};
    endfunction
    function automatic logic [63:0] ex_data(input logic [31:0] d, input logic [3:0] be);
        return {4'b0001, be, 2'b00, 22'h0, d};
    endfunction
    function automatic logic [63:0] ex_herr();
        return {4'b0100, 60'h0};
    endfunction
    function automatic logic [63:0] ex_perr();
        return {4'b1000, 60'h0};
    endfunction

    task automatic push_exp(input int which, input logic [63:0] v);
        if (which == 2) q2.push_back(v);
        else q4.push_back(v);
    endtask

    always @(negedge clk) begin
        if (!reset && (dv2 | hv2 | he2 | pe2)) begin
            obs2 = pack(dv2, hv2, he2, pe2, {2'b00, be2}, fs2, fe2, {16'h0, dout2}, id2, wc2);
            if (q2.size() == 0) chk("unexpected2", obs2, 64'h0);
            else begin
                exp2 = q2.pop_front();
                chk("event2", obs2, exp2);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (dv4 | hv4 | he4 | pe4)) begin
            obs4 = pack(dv4, hv4, he4, pe4, be4, fs4, fe4, dout4, id4, wc4);
            if (q4.size() == 0) chk("unexpected4", obs4, 64'h0);
            else begin
                exp4 = q4.pop_front();
                chk("event4", obs4, exp4);
            end
        end
    end

    task automatic make_hdr(input logic [7:0] id, input logic [15:0] wc, input logic [23:0] flip);
        logic [23:0] d;
        d = {wc, id} ^ flip;
        pkt.delete();
        pkt.push_back(d[7:0]);
        pkt.push_back(d[15:8]);
        pkt.push_back(d[23:16]);
        pkt.push_back(ecc_model({wc, id}));
    endtask

    task automatic build_long(input logic [7:0] id, input logic [15:0] wc, input logic [23:0] flip,
                              input logic [7:0] base, input logic [15:0] crc);
        make_hdr(id, wc, flip);
        for (int i = 0; i < int'(wc); i++) pkt.push_back(8'(base + i));
        pkt.push_back(crc[7:0]);
        pkt.push_back(crc[15:8]);
    endtask

    task automatic exp_payload(input int which, input int nl, input logic [15:0] wc, input logic [7:0] base);
        logic [31:0] d;
        logic [3:0]  be;
        for (int w = 0; w * nl < int'(wc); w++) begin
            d  = '0;
            be = '0;
            for (int l = 0; l < nl; l++) begin
                if (w * nl + l < int'(wc)) begin
                    be[l]       = 1'b1;
                    d[8*l +: 8] = 8'(base + w * nl + l);
                end
            end
            push_exp(which, ex_data(d, be));
        end
    endtask

    // Leader zeros, sync byte on the lanes in sync_mask, packet bytes round-robin, then trailer.
    task automatic burst(input int which, input int drop_at, input logic [3:0] sync_mask);
        logic [7:0] sy;
        logic [7:0] bb;
        logic [3:0] lv;
        int nl, nw, total;
        sy = 8'hB8;
        nl = (which == 4) ? 4 : 2;
        while (pkt.size() % nl != 0) pkt.push_back(8'h00);
        nw    = pkt.size() / nl;
        total = 16 + 8 * nw + 16;
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            if (c == total || (drop_at >= 0 && c >= drop_at)) begin
                lane2 = '0; hs2 = 1'b0; lane4 = '0; hs4 = 1'b0;
                break;
            end
            lv = '0;
            for (int l = 0; l < nl; l++) begin
                if (c >= 8 && c < 16) lv[l] = sync_mask[l] & sy[c - 8];
                else if (c >= 16 && c < 16 + 8 * nw) begin
                    bb    = pkt[((c - 16) / 8) * nl + l];
                    lv[l] = bb[(c - 16) % 8];
                end
            end
            if (which == 4) begin lane4 = lv; hs4 = 1'b1; end
            else begin lane2 = lv[1:0]; hs2 = 1'b1; end
        end
        repeat (16) @(negedge clk);
        if (which == 4) begin chk("pending4", 64'(q4.size()), 64'd0); q4.delete(); end
        else begin chk("pending2", 64'(q2.size()), 64'd0); q2.delete(); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; lane2 = '0; hs2 = 1'b0; lane4 = '0; hs4 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_strobes2", {58'h0, dv2, hv2, fs2, fe2, he2, pe2}, 64'h0);
        chk("rst_fields2", {dout2, be2, id2, wc2, crc2}, 64'h0);
        chk("rst_strobes4", {58'h0, dv4, hv4, fs4, fe4, he4, pe4}, 64'h0);
        chk("rst_fields4", {dout4, id4, wc4, be4, 4'h0}, 64'h0);
        chk("rst_crc4", {48'h0, crc4}, 64'h0);

        // Frame start short packet, ECC 0x07
        make_hdr(8'h00, 16'h0000, 24'h0);
        push_exp(2, ex_hdr(1'b1, 1'b0, 8'h00, 16'h0000));
        burst(2, -1, 4'hF);

        // Long packet with partial final word and footer split across words
        build_long(8'h2B, 16'd5, 24'h0, 8'h11, 16'hBBAA);
        push_exp(2, ex_hdr(1'b0, 1'b0, 8'h2B, 16'd5));
        exp_payload(2, 2, 16'd5, 8'h11);
        burst(2, -1, 4'hF);
        chk("crc2_wc5", {48'h0, crc2}, 64'hBBAA);

        // Single header bit error (WC bit 1)
        build_long(8'h2A, 16'd3, 24'h000200, 8'h31, 16'hFFEE);
`ifdef MIPI_RX_ECC_CORRECT_EN
        push_exp(2, ex_hdr(1'b0, 1'b0, 8'h2A, 16'd3));
        exp_payload(2, 2, 16'd3, 8'h31);
        burst(2, -1, 4'hF);
        chk("crc2_corr", {48'h0, crc2}, 64'hFFEE);
`else
        push_exp(2, ex_herr());
        burst(2, -1, 4'hF);
        chk("crc2_hold", {48'h0, crc2}, 64'hBBAA);
`endif

        // Double bit error is never correctable
        build_long(8'h2B, 16'd5, 24'h000003, 8'h11, 16'h1111);
        push_exp(2, ex_herr());
        burst(2, -1, 4'hF);

        // Sync on lane 0 only, then a clean frame end in the next burst
        make_hdr(8'h00, 16'h0000, 24'h0);
        push_exp(2, ex_perr());
        burst(2, -1, 4'b0001);
        make_hdr(8'h01, 16'h0007, 24'h0);
        push_exp(2, ex_hdr(1'b0, 1'b1, 8'h01, 16'h0007));
        burst(2, -1, 4'hF);

        // hs_active lost after the first payload word, then a clean burst
        build_long(8'h2B, 16'd10, 24'h0, 8'h41, 16'h5A5A);
        push_exp(2, ex_hdr(1'b0, 1'b0, 8'h2B, 16'd10));
        push_exp(2, ex_data(32'h0000_4241, 4'b0011));
        push_exp(2, ex_perr());
        burst(2, 44, 4'hF);
        build_long(8'h2B, 16'd2, 24'h0, 8'h51, 16'h6261);
        push_exp(2, ex_hdr(1'b0, 1'b0, 8'h2B, 16'd2));
        exp_payload(2, 2, 16'd2, 8'h51);
        burst(2, -1, 4'hF);
        chk("crc2_after_drop", {48'h0, crc2}, 64'h6261);

        // Four lanes: one full word
        build_long(8'h2C, 16'd4, 24'h0, 8'h21, 16'hDDCC);
        push_exp(4, ex_hdr(1'b0, 1'b0, 8'h2C, 16'd4));
        exp_payload(4, 4, 16'd4, 8'h21);
        burst(4, -1, 4'hF);
        chk("crc4_wc4", {48'h0, crc4}, 64'hDDCC);

        // Four lanes, VC 1, footer inside the last payload word
        build_long(8'h6B, 16'd6, 24'h0, 8'h71, 16'h8281);
        push_exp(4, ex_hdr(1'b0, 1'b0, 8'h6B, 16'd6));
        exp_payload(4, 4, 16'd6, 8'h71);
        burst(4, -1, 4'hF);
        chk("crc4_wc6", {48'h0, crc4}, 64'h8281);

        // Word count exactly at MAX_WC, footer in its own word
        build_long(8'h2B, 16'd100, 24'h0, 8'h80, 16'h1234);
        push_exp(4, ex_hdr(1'b0, 1'b0, 8'h2B, 16'd100));
        exp_payload(4, 4, 16'd100, 8'h80);
        burst(4, -1, 4'hF);
        chk("crc4_max", {48'h0, crc4}, 64'h1234);

        // One above MAX_WC
        build_long(8'h2B, 16'd101, 24'h0, 8'h80, 16'h9999);
        push_exp(4, ex_herr());
        burst(4, -1, 4'hF);
        chk("crc4_over", {48'h0, crc4}, 64'h1234);
        chk("wc4_hold", {48'h0, wc4}, 64'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
